// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between a CPU port (A)
// and a DMA/video port (B), with a bounded lock and one-cycle read-data steering.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    input  logic              A_LOCK,
    output logic              A_GNT,
    output logic              A_RVALID,
    output logic [DATA_W-1:0] A_RDATA,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    input  logic              B_LOCK,
    output logic              B_GNT,
    output logic              B_RVALID,
    output logic [DATA_W-1:0] B_RDATA,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DIN,
    input  logic [DATA_W-1:0] MEM_DOUT
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } own_t;

    localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

    logic       prio_q, prio_d;
    own_t       lock_own_q, lock_own_d;
    logic [3:0] lock_cnt_q, lock_cnt_d;
    own_t       rd_own_q, rd_own_d;

    logic lock_live;
    logic gnt_a, gnt_b;

    // A saturated lock drops out of arbitration so the other port can get through.
    assign lock_live = (lock_cnt_q < LOCK_MAX);

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (lock_own_q == OWN_A && A_REQ && lock_live) begin
            gnt_a = 1'b1;
        end else if (lock_own_q == OWN_B && B_REQ && lock_live) begin
            gnt_b = 1'b1;
        end else if (A_REQ && !B_REQ) begin
            gnt_a = 1'b1;
        end else if (B_REQ && !A_REQ) begin
            gnt_b = 1'b1;
        end else if (A_REQ && B_REQ) begin
            gnt_a = ~prio_q;
            gnt_b = prio_q;
        end
    end

    always_comb begin
        MEM_WE   = 1'b0;
        MEM_ADDR = A_ADDR;
        MEM_DIN  = A_WDATA;
        if (gnt_a) begin
            MEM_WE = A_WE;
        end else if (gnt_b) begin
            MEM_WE   = B_WE;
            MEM_ADDR = B_ADDR;
            MEM_DIN  = B_WDATA;
        end
    end

    always_comb begin
        prio_d     = prio_q;
        lock_own_d = OWN_NONE;
        lock_cnt_d = 4'd0;
        rd_own_d   = OWN_NONE;
        if (gnt_a) begin
            prio_d = 1'b1;
            if (!A_WE) rd_own_d = OWN_A;
            if (A_LOCK) begin
                lock_own_d = OWN_A;
                if (lock_own_q == OWN_A)
                    lock_cnt_d = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 4'd1;
                else
                    lock_cnt_d = 4'd1;
            end
        end else if (gnt_b) begin
            prio_d = 1'b0;
            if (!B_WE) rd_own_d = OWN_B;
            if (B_LOCK) begin
                lock_own_d = OWN_B;
                if (lock_own_q == OWN_B)
                    lock_cnt_d = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 4'd1;
                else
                    lock_cnt_d = 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prio_q     <= 1'b0;
            lock_own_q <= OWN_NONE;
            lock_cnt_q <= 4'd0;
            rd_own_q   <= OWN_NONE;
        end else begin
            prio_q     <= prio_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
            rd_own_q   <= rd_own_d;
        end
    end

    assign A_GNT    = gnt_a;
    assign B_GNT    = gnt_b;
    assign A_RVALID = (rd_own_q == OWN_A);
    assign B_RVALID = (rd_own_q == OWN_B);
    assign A_RDATA  = MEM_DOUT;
    assign B_RDATA  = MEM_DOUT;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a write-first synchronous RAM model behind it.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        A_REQ, A_WE, A_LOCK, B_REQ, B_WE, B_LOCK;
    logic [15:0] A_ADDR, B_ADDR;
    logic [7:0]  A_WDATA, B_WDATA;
    logic        A_GNT, B_GNT, A_RVALID, B_RVALID;
    logic [7:0]  A_RDATA, B_RDATA;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_DIN;
    logic [7:0]  MEM_DOUT;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] ram [0:65535];

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MEM_WE) ram[MEM_ADDR] <= MEM_DIN;
        MEM_DOUT <= MEM_WE ? MEM_DIN : ram[MEM_ADDR];
    end

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_LOCK(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA), .A_LOCK(A_LOCK),
        .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA), .B_LOCK(B_LOCK),
        .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; #1 lets combinational grants settle.
    task automatic drive(input logic a_req, input logic a_we, input logic [15:0] a_addr,
                         input logic [7:0] a_wdata, input logic a_lock,
                         input logic b_req, input logic b_we, input logic [15:0] b_addr,
                         input logic [7:0] b_wdata, input logic b_lock);
        A_REQ = a_req; A_WE = a_we; A_ADDR = a_addr; A_WDATA = a_wdata; A_LOCK = a_lock;
        B_REQ = b_req; B_WE = b_we; B_ADDR = b_addr; B_WDATA = b_wdata; B_LOCK = b_lock;
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic ea, input logic eb);
        chk({tag, "_a_gnt"}, 32'(A_GNT), 32'(ea));
        chk({tag, "_b_gnt"}, 32'(B_GNT), 32'(eb));
    endtask

    initial begin
        RESET_N = 1'b0;
        drive(0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0);
        chk("rst_a_rvalid", 32'(A_RVALID), 0);
        chk("rst_b_rvalid", 32'(B_RVALID), 0);
        chk_gnt("rst", 0, 0);
        chk("rst_mem_we", 32'(MEM_WE), 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Single port: write then read 0x0107
        drive(1, 1, 16'h0107, 8'h5A, 0, 0, 0, 16'h0000, 8'h00, 0);
        chk_gnt("sp_wr", 1, 0);
        chk("sp_wr_mem_we", 32'(MEM_WE), 1);
        chk("sp_wr_mem_addr", 32'(MEM_ADDR), 32'h0107);
        chk("sp_wr_mem_din", 32'(MEM_DIN), 32'h5A);
        @(negedge CLK);
        drive(1, 0, 16'h0107, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0);
        chk_gnt("sp_rd", 1, 0);
        chk("sp_rd_mem_we", 32'(MEM_WE), 0);
        chk("sp_wr_no_rvalid", 32'(A_RVALID), 0);
        @(negedge CLK);
        drive(0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0);
        chk("sp_a_rvalid", 32'(A_RVALID), 1);
        chk("sp_a_rdata", 32'(A_RDATA), 32'h5A);
        chk("sp_b_rvalid", 32'(B_RVALID), 0);
        @(negedge CLK);
        chk("sp_a_rvalid_drop", 32'(A_RVALID), 0);

        // Preload contention data
        drive(1, 1, 16'h0110, 8'hBB, 0, 0, 0, 16'h0000, 8'h00, 0);
        chk_gnt("pre_a", 1, 0);
        @(negedge CLK);
        drive(0, 0, 16'h0000, 8'h00, 0, 1, 1, 16'h0304, 8'hFF, 0);
        chk_gnt("pre_b", 0, 1);
        chk("pre_b_mem_addr", 32'(MEM_ADDR), 32'h0304);
        chk("pre_b_mem_din", 32'(MEM_DIN), 32'hFF);
        @(negedge CLK);

        // Reset mid-read: read granted, reset lands before RVALID is consumed
        drive(1, 0, 16'h0100, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0);
        chk_gnt("rmr_gnt", 1, 0);
        @(negedge CLK);
        drive(0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0);
        chk("rmr_rvalid_before", 32'(A_RVALID), 1);
        RESET_N = 1'b0;
        #1;
        chk("rmr_rvalid_reset", 32'(A_RVALID), 0);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("rmr_rvalid_after", 32'(A_RVALID), 0);

        // Contention from reset: prio back to A, then strict alternation
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 16'h0110, 8'h00, 0, 1, 0, 16'h0304, 8'h00, 0);
            chk_gnt($sformatf("cont%0d", i), (i % 2 == 0), (i % 2 == 1));
            if (i > 0) begin
                chk($sformatf("cont%0d_a_rvalid", i), 32'(A_RVALID), 32'(i % 2 == 1));
                chk($sformatf("cont%0d_b_rvalid", i), 32'(B_RVALID), 32'(i % 2 == 0));
                chk($sformatf("cont%0d_rdata", i), 32'((i % 2 == 1) ? A_RDATA : B_RDATA),
                    (i % 2 == 1) ? 32'hBB : 32'hFF);
            end
            @(negedge CLK);
        end
        drive(0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0);
        chk("cont_tail_b_rvalid", 32'(B_RVALID), 1);
        chk("cont_tail_b_rdata", 32'(B_RDATA), 32'hFF);
        @(negedge CLK);

        // Lock: A holds LOCK for 4 grants, then the saturated lock yields to B
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 16'h0110, 8'h00, 1, 1, 0, 16'h0304, 8'h00, 0);
            chk_gnt($sformatf("lock%0d", k), (k < 4), (k == 4));
            @(negedge CLK);
        end
        for (int k = 5; k < 9; k++) begin
            drive(1, 0, 16'h0110, 8'h00, 0, 1, 0, 16'h0304, 8'h00, 0);
            chk_gnt($sformatf("lock_alt%0d", k), (k % 2 == 1), (k % 2 == 0));
            @(negedge CLK);
        end

        // Lock release: two locked grants, one unlocked grant, then B
        drive(1, 0, 16'h0110, 8'h00, 1, 1, 0, 16'h0304, 8'h00, 0);
        chk_gnt("rel0", 1, 0);
        @(negedge CLK);
        drive(1, 0, 16'h0110, 8'h00, 1, 1, 0, 16'h0304, 8'h00, 0);
        chk_gnt("rel1", 1, 0);
        @(negedge CLK);
        drive(1, 0, 16'h0110, 8'h00, 0, 1, 0, 16'h0304, 8'h00, 0);
        chk_gnt("rel2", 1, 0);
        @(negedge CLK);
        drive(1, 0, 16'h0110, 8'h00, 0, 1, 0, 16'h0304, 8'h00, 0);
        chk_gnt("rel3", 0, 1);
        @(negedge CLK);
        drive(1, 0, 16'h0110, 8'h00, 0, 1, 0, 16'h0304, 8'h00, 0);
        chk_gnt("rel4", 1, 0);
        @(negedge CLK);

        // A-only write leaves prio favouring B across the idle stretch
        drive(1, 1, 16'h0200, 8'h33, 0, 0, 0, 16'h0000, 8'h00, 0);
        chk_gnt("pre_idle", 1, 0);
        @(negedge CLK);
        for (int j = 0; j < 10; j++) begin
            drive(0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0);
            chk_gnt($sformatf("idle%0d", j), 0, 0);
            chk($sformatf("idle%0d_mem_we", j), 32'(MEM_WE), 0);
            chk($sformatf("idle%0d_rvalid", j), 32'({A_RVALID, B_RVALID}), 0);
            @(negedge CLK);
        end
        drive(1, 0, 16'h0200, 8'h00, 0, 1, 0, 16'h0304, 8'h00, 0);
        chk_gnt("idle_prio", 0, 1);
        @(negedge CLK);
        drive(1, 0, 16'h0200, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0);
        chk_gnt("raw_a", 1, 0);
        chk("raw_b_rvalid", 32'(B_RVALID), 1);
        @(negedge CLK);
        drive(0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0);
        chk("raw_a_rdata", 32'(A_RDATA), 32'h33);
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single-port synchronous 64K x 8 RAM between two requesters: port A (6502 core) and port B (DMA/video fetch).
- Sits between the requesters and the RAM's CLK/WE/Address/DataIn/DataOut interface.
- Grants one access per cycle using round-robin priority.
- Supports a bounded LOCK so the core can complete read-modify-write sequences without interleaving.
- Tracks the RAM's one-cycle read latency and steers returned data to the owning port.

Parameters:
- ADDR_W, 16, address width on both ports and the RAM side.
- DATA_W, 8, data width.
- MAX_LOCK, 4, maximum consecutive locked grants before the lock is overridden for one arbitration (range 1..15).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- A_REQ  input  1  port A access request.
- A_WE  input  1  port A write enable (1 = write, 0 = read).
- A_ADDR  input  ADDR_W  port A address.
- A_WDATA  input  DATA_W  port A write data.
- A_LOCK  input  1  port A requests to keep the grant next cycle.
- A_GNT  output  1  port A access accepted this cycle (combinational).
- A_RVALID  output  1  port A read data valid (registered).
- A_RDATA  output  DATA_W  port A read data.
- B_REQ, B_WE, B_ADDR, B_WDATA, B_LOCK, B_GNT, B_RVALID, B_RDATA: same as port A, for port B.
- MEM_WE  output  1  to RAM WE.
- MEM_ADDR  output  ADDR_W  to RAM Address.
- MEM_DIN  output  DATA_W  to RAM DataIn.
- MEM_DOUT  input  DATA_W  from RAM DataOut.

Behaviour:
- State registers:
  - prio: 0 = A favoured, 1 = B favoured.
  - lock_own: none / A / B.
  - lock_cnt: 4-bit counter.
  - rd_own: none / A / B, owner of the in-flight read.
- Reset (RESET_N low, asynchronous): prio=0, lock_own=none, lock_cnt=0, rd_own=none. A_RVALID=B_RVALID=0. Any in-flight read is discarded.
- Grant (combinational, from REQ inputs and registered state):
  - If lock_own=X, X_REQ=1 and lock_cnt<MAX_LOCK: grant X.
  - Otherwise, if only one port requests: grant it.
  - Otherwise, if both request: grant the port selected by prio.
  - Otherwise: no grant.
  - At most one of A_GNT/B_GNT is high in any cycle.
- RAM mux:
  - On grant to X: MEM_ADDR=X_ADDR, MEM_DIN=X_WDATA, MEM_WE=X_WE.
  - No grant: MEM_WE=0, MEM_ADDR=A_ADDR, MEM_DIN=A_WDATA.
- Writes:
  - Committed at the rising edge that ends the grant cycle.
  - No RVALID is produced for a write.
- Reads:
  - Grant in cycle t causes X_RVALID=1 in cycle t+1, with X_RDATA=MEM_DOUT (combinational passthrough). Latency is exactly 1.
  - rd_own is updated every edge: X if X was granted a read, else none.
  - A port may be granted back-to-back reads, giving one result per cycle.
  - X_RDATA is unspecified whenever X_RVALID=0.
- Round-robin update at each edge with a grant to X: prio points to the other port. No grant: prio is held.
- Lock sequencing at each edge:
  - Grant to X with X_LOCK=1:
    - If lock_own=X, lock_cnt increments, saturating at MAX_LOCK.
    - Otherwise lock_own=X and lock_cnt=1.
  - Grant to X with X_LOCK=0, or no grant: lock_own=none, lock_cnt=0.
  - When lock_cnt=MAX_LOCK, the lock is ignored for arbitration. If the other port requests, it wins. The resulting grant to the other port clears or replaces the lock.
- Read-after-write, same address, consecutive cycles: the read returns the newly written data, because the RAM is write-then-read registered.
- Simultaneous A write and B read of the same address: only one is granted. Ordering follows the grant sequence.
- A requester whose REQ is high and GNT is low must hold its REQ/WE/ADDR/WDATA stable. The arbiter does not latch requests.

Test Plan:
- Reset mid-read: A read of 0x0100 granted, RESET_N pulsed low before the next edge -> A_RVALID stays 0; all state returns to reset values.
- Single port: A writes 0x5A to 0x0107, then reads 0x0107 -> A_GNT=1 in both cycles; A_RVALID=1 with A_RDATA=0x5A exactly one cycle after the read grant; B_RVALID=0 throughout.
- Contention: A and B request reads continuously from reset -> grants alternate A,B,A,B. Each RVALID follows its own grant by one cycle with correct data (A at 0x0110=0xBB, B at 0x0304=0xFF, preloaded by bench writes).
- Lock with MAX_LOCK=4: A holds REQ and LOCK, B requests continuously -> A granted 4 consecutive cycles, then B granted; afterwards strict alternation.
- Lock release: A locks for 2 cycles, then drops A_LOCK with B pending -> B granted on the next cycle; lock_cnt cleared.
- Idle: no requests for 10 cycles -> MEM_WE=0, no GNT, no RVALID, prio unchanged.
